maxpool2x2_stream: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage between the convolution/ReLU output and the fully-connected digit classifier. It accepts one signed 8-bit activation per valid cycle in row-major raster order. For each 2×2 window it emits one signed 8-bit maximum, in the same order the FC stage accumulates features. Storage is one half-width line buffer. There is no backpressure: the downstream stage accepts every valid output.

---
 rtl/maxpool2x2_stream.sv | 105 ++++++++++
 tb/tb_maxpool2x2_stream.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - 2x2 stride-2 streaming signed max-pool with a half-width line buffer
module maxpool2x2_stream #(
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] pixel_in,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] feature_out,
  output logic                     last_out
);

  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  // Last column/row that still belongs to a full 2x2 window; an odd
  // trailing column or row is counted but never pooled.
  localparam logic [CW-1:0] COL_WIN_LAST = CW'(2 * OW - 1);
  localparam logic [RW-1:0] ROW_WIN_LAST = RW'(2 * OH - 1);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [DATA_W-1:0] r_h;
  logic                     r_valid;
  logic                     r_last;
  logic signed [DATA_W-1:0] r_feat;
  logic signed [DATA_W-1:0] r_linebuf [OW];

  logic                     w_in_win;
  logic                     w_pool_h;
  logic                     w_lb_wr;
  logic                     w_emit;
  logic [AW-1:0]            w_lb_idx;
  logic signed [DATA_W-1:0] w_hmax;
  logic signed [DATA_W-1:0] w_lb_rd;
  logic signed [DATA_W-1:0] w_vmax;

  assign w_in_win = (r_col <= COL_WIN_LAST) && (r_row <= ROW_WIN_LAST);
  // The second pixel of a horizontal pair completes the row-wise max.
  assign w_pool_h = valid_in && w_in_win && r_col[0];
  // Even rows park their pair max; odd rows combine it with the parked one.
  assign w_lb_wr  = w_pool_h && !r_row[0];
  assign w_emit   = w_pool_h && r_row[0];
  assign w_lb_idx = AW'(r_col >> 1);

  assign w_hmax  = (r_h > pixel_in) ? r_h : pixel_in;
  assign w_lb_rd = r_linebuf[w_lb_idx];
  assign w_vmax  = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

  assign valid_out   = r_valid;
  assign feature_out = r_feat;
  assign last_out    = r_last;

  // Raster counters, horizontal holding register and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_h     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_feat  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      if (valid_in) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row == ROW_LAST) begin
            r_row <= '0;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_in_win && !r_col[0]) begin
          r_h <= pixel_in;
        end
      end
      if (w_emit) begin
        r_valid <= 1'b1;
        r_feat  <= w_vmax;
        r_last  <= (r_row == ROW_WIN_LAST) && (r_col == COL_WIN_LAST);
      end
    end
  end

  // Line buffer holds even-row pair maxima; it needs no reset because every
  // odd-row read is preceded by an even-row write of the same entry.
  always_ff @(posedge clk) begin
    if (!rst && w_lb_wr) begin
      r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - bench for maxpool2x2_stream at 4x4, 5x5 and 26x26
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              vin  [3];
  logic              rin  [3];
  logic signed [7:0] pin  [3];
  logic              vout [3];
  logic              lout [3];
  logic signed [7:0] fout [3];

  int checks = 0;
  int errors = 0;

  int img_w [3] = '{4, 5, 26};
  int img_h [3] = '{4, 5, 26};
  int pos   [3];
  int img   [3][676];
  bit pend      [3];
  bit pend_last [3];
  logic signed [7:0] pend_val [3];
  int out_cnt  [3];
  int last_cnt [3];
  int frame [676];

  maxpool2x2_stream #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_d4 (
    .clk(clk), .rst(rin[0]), .valid_in(vin[0]), .pixel_in(pin[0]),
    .valid_out(vout[0]), .feature_out(fout[0]), .last_out(lout[0])
  );
  maxpool2x2_stream #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) u_d5 (
    .clk(clk), .rst(rin[1]), .valid_in(vin[1]), .pixel_in(pin[1]),
    .valid_out(vout[1]), .feature_out(fout[1]), .last_out(lout[1])
  );
  maxpool2x2_stream #(.IMG_W(26), .IMG_H(26), .DATA_W(8)) u_d26 (
    .clk(clk), .rst(rin[2]), .valid_in(vin[2]), .pixel_in(pin[2]),
    .valid_out(vout[2]), .feature_out(fout[2]), .last_out(lout[2])
  );

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: a pixel at an odd row/odd column inside the pooled area closes
  // a 2x2 window whose max is taken from the stored image.
  task automatic model_accept(input int d, input int px);
    int w = img_w[d];
    int h = img_h[d];
    int r = pos[d] / w;
    int c = pos[d] % w;
    int m;
    img[d][pos[d]] = px;
    if ((r % 2 == 1) && (c % 2 == 1) && (r < (h / 2) * 2) && (c < (w / 2) * 2)) begin
      m = imax(imax(img[d][(r-1)*w + c-1], img[d][(r-1)*w + c]),
               imax(img[d][r*w + c-1], px));
      pend[d]      = 1'b1;
      pend_val[d]  = 8'(m);
      pend_last[d] = (r / 2 == h / 2 - 1) && (c / 2 == w / 2 - 1);
    end
    pos[d] = (pos[d] + 1) % (w * h);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      checks++;
      assert (vout[k] === pend[k]) else begin
        errors++;
        $error("FAIL valid_out[%0d] observed %0b expected %0b", k, vout[k], pend[k]);
      end
      if (pend[k]) begin
        checks++;
        assert (fout[k] === pend_val[k]) else begin
          errors++;
          $error("FAIL feature_out[%0d] observed %0d expected %0d", k, fout[k], pend_val[k]);
        end
        checks++;
        assert (lout[k] === pend_last[k]) else begin
          errors++;
          $error("FAIL last_out[%0d] observed %0b expected %0b", k, lout[k], pend_last[k]);
        end
        out_cnt[k]++;
        if (lout[k] === 1'b1) last_cnt[k]++;
      end else begin
        checks++;
        assert (lout[k] === 1'b0) else begin
          errors++;
          $error("FAIL idle_last_out[%0d] observed %0b expected 0", k, lout[k]);
        end
      end
    end
  endtask

  task automatic step(input int d, input bit v, input int px, input bit r);
    @(negedge clk);
    check_outputs();
    for (int k = 0; k < 3; k++) begin
      vin[k]  = 1'b0;
      rin[k]  = 1'b0;
      pend[k] = 1'b0;
    end
    vin[d] = v;
    rin[d] = r;
    pin[d] = 8'(px);
    if (r) pos[d] = 0;
    else if (v) model_accept(d, px);
  endtask

  task automatic drain(input int d);
    step(d, 1'b0, 0, 1'b0);
    step(d, 1'b0, 0, 1'b0);
  endtask

  task automatic check_count(input int d, input int eo, input int el);
    checks++;
    assert (out_cnt[d] === eo) else begin
      errors++;
      $error("FAIL out_count[%0d] observed %0d expected %0d", d, out_cnt[d], eo);
    end
    checks++;
    assert (last_cnt[d] === el) else begin
      errors++;
      $error("FAIL last_count[%0d] observed %0d expected %0d", d, last_cnt[d], el);
    end
    out_cnt[d]  = 0;
    last_cnt[d] = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rin[k] = 1'b1; vin[k] = 1'b0; pin[k] = '0;
      pos[k] = 0; pend[k] = 1'b0; out_cnt[k] = 0; last_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      assert (vout[k] === 1'b0 && lout[k] === 1'b0 && fout[k] === 8'sd0) else begin
        errors++;
        $error("FAIL reset_state[%0d] observed v=%0b l=%0b f=%0d expected 0 0 0",
               k, vout[k], lout[k], fout[k]);
      end
    end

    // 4x4 ramp back-to-back
    for (int i = 0; i < 16; i++) step(0, 1'b1, i, 1'b0);
    drain(0);
    check_count(0, 4, 1);
    checks++;
    assert (fout[0] === 8'sd15) else begin
      errors++;
      $error("FAIL hold_feature observed %0d expected 15", fout[0]);
    end

    // 4x4 all-negative ramp
    for (int i = 0; i < 16; i++) step(0, 1'b1, -128 + i, 1'b0);
    drain(0);
    check_count(0, 4, 1);

    // 4x4 ramp with random gaps carrying garbage data
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(5)) step(0, 1'b0, int'($urandom_range(255)), 1'b0);
      step(0, 1'b1, i, 1'b0);
    end
    drain(0);
    check_count(0, 4, 1);

    // 5x5, two back-to-back frames
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 25; i++) step(1, 1'b1, i, 1'b0);
    drain(1);
    check_count(1, 8, 2);

    // 26x26, two frames with the max planted at window position (1,0)
    for (int f = 0; f < 2; f++) begin
      for (int wr = 0; wr < 13; wr++) begin
        for (int wc = 0; wc < 13; wc++) begin
          int m = int'($urandom_range(254)) - 127;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              frame[(2*wr + dr)*26 + 2*wc + dc] =
                (dr == 1 && dc == 0) ? m : -128 + int'($urandom_range(m + 127));
        end
      end
      for (int i = 0; i < 676; i++) step(2, 1'b1, frame[i], 1'b0);
    end
    drain(2);
    check_count(2, 338, 2);

    // 4x4 reset after pixel 6; the pixel offered with reset is dropped
    for (int i = 0; i < 7; i++) step(0, 1'b1, i, 1'b0);
    step(0, 1'b1, 100, 1'b1);
    for (int i = 0; i < 16; i++) step(0, 1'b1, i, 1'b0);
    drain(0);
    check_count(0, 5, 1);

    // 4x4 reset inside a partial window, then a negative frame
    for (int i = 0; i < 5; i++) step(0, 1'b1, 50 + i, 1'b0);
    step(0, 1'b0, 0, 1'b1);
    drain(0);
    check_count(0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1'b1, -128 + i, 1'b0);
    drain(0);
    check_count(0, 4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
